// File: rtl/bch_traffic_checker_if.sv
// Handshake bundle between the traffic checker and the BCH encode/decode chain.
// The master side (the checker) sources frames toward the encoder and sinks
// decoder results; the slave side is the code chain under test.
interface bch_traffic_checker_if #(
  parameter int N      = 31,
  parameter int K      = 11,
  parameter int NERR_W = 3
);
  logic              vdin;
  logic              rdin;
  logic [K-1:0]      din;
  logic [N-1:0]      error;
  logic [NERR_W-1:0] nerr;
  logic [K-1:0]      dout;
  logic              vdout;

  modport master (output vdin, din, error, nerr, input rdin, dout, vdout);
  modport slave  (input vdin, din, error, nerr, output rdin, dout, vdout);
endinterface

// File: rtl/bch_traffic_checker.sv
// BCH traffic checker: LFSR-driven frame/error-mask generator plus an in-order
// scoreboard on the decoder output. Build option: define BCH_TRAFFIC_BURST_EN
// to add burst_i, which turns the error mask into one contiguous (wrapping)
// run of nerr bits instead of independent positions.
//
// state    | meaning
// IDLE     | waiting for enable and FIFO space
// GEN_DATA | drawing K data bits, 32 per cycle
// GEN_NERR | drawing the error count (out-of-range draws retried)
// GEN_POS  | drawing error positions (out-of-range / duplicate retried)
// ISSUE    | frame presented on vdin until the encoder accepts it
module bch_traffic_checker #(
  parameter int          N       = 31,
  parameter int          K       = 11,
  parameter int          T       = 5,
  parameter int          MAX_ERR = 5,
  parameter int          DEPTH   = 8,
  parameter logic [31:0] SEED    = 32'd1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable_i,
`ifdef BCH_TRAFFIC_BURST_EN
  input  logic                  burst_i,
`endif
  bch_traffic_checker_if.master bus,
  output logic                  wrong_now_o,
  output logic                  wrong_o,
  output logic                  underflow_o,
  output logic [31:0]           frames_o,
  output logic [31:0]           uncorrectable_o,
  output logic                  busy_o
);

  localparam int NERR_W = (MAX_ERR > 0) ? $clog2(MAX_ERR + 1) : 1;
  localparam int POS_W  = (N > 1) ? $clog2(N) : 1;
  localparam int CHUNKS = (K + 31) / 32;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam int AW     = $clog2(DEPTH);
  localparam logic [31:0] SEED_INIT = (SEED == 32'd0) ? 32'd1 : SEED;

  typedef enum logic [2:0] {IDLE, GEN_DATA, GEN_NERR, GEN_POS, ISSUE} state_t;

  state_t            state_q;
  logic [31:0]       lfsr_q;
  logic [CW-1:0]     chunk_q;
  logic [K-1:0]      din_q;
  logic [N-1:0]      err_q;
  logic [NERR_W-1:0] nerr_q;
  logic [NERR_W-1:0] rem_q;
  logic              vdin_q;
`ifdef BCH_TRAFFIC_BURST_EN
  logic              burst_q;
`endif

  logic [K:0]        mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              wrong_now_q, wrong_q, underflow_q;
  logic [31:0]       frames_q, unc_q;

  logic              draw, empty, full, push, pop, mism;
  logic [NERR_W-1:0] nerr_draw;
  logic [POS_W-1:0]  pos_draw;
  logic [K-1:0]      head_data;
  logic              head_corr;

  // Galois form of x^32+x^22+x^2+x+1, shifting right
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  assign draw      = (state_q == GEN_DATA) || (state_q == GEN_NERR) || (state_q == GEN_POS);
  assign nerr_draw = (MAX_ERR == 0) ? '0 : lfsr_q[NERR_W-1:0];
  assign pos_draw  = lfsr_q[POS_W-1:0];
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push      = vdin_q && bus.rdin;
  assign pop       = bus.vdout && !empty;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]][K:1];
  assign head_corr = mem_q[rd_ptr_q[AW-1:0]][0];
  assign mism      = bus.vdout && (empty || (head_corr && (bus.dout != head_data)));

  // LFSR steps once per draw cycle, holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= SEED_INIT;
    else if (draw) lfsr_q <= lfsr_step(lfsr_q);
  end

  // Frame generation FSM with registered frame outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      chunk_q <= '0;
      din_q   <= '0;
      err_q   <= '0;
      nerr_q  <= '0;
      rem_q   <= '0;
      vdin_q  <= 1'b0;
`ifdef BCH_TRAFFIC_BURST_EN
      burst_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (enable_i && !full) begin
            state_q <= GEN_DATA;
            chunk_q <= '0;
`ifdef BCH_TRAFFIC_BURST_EN
            burst_q <= burst_i;
`endif
          end
        end
        GEN_DATA: begin
          for (int b = 0; b < K; b++)
            if ((b / 32) == int'(chunk_q)) din_q[b] <= lfsr_q[b % 32];
          if (int'(chunk_q) == CHUNKS - 1) state_q <= GEN_NERR;
          else chunk_q <= chunk_q + CW'(1);
        end
        GEN_NERR: begin
          if (int'(nerr_draw) <= MAX_ERR) begin
            nerr_q <= nerr_draw;
            rem_q  <= nerr_draw;
            // cleared even for nerr == 0 so a stale mask never rides along
            err_q  <= '0;
            if (nerr_draw == '0) begin
              state_q <= ISSUE;
              vdin_q  <= 1'b1;
            end else begin
              state_q <= GEN_POS;
            end
          end
        end
        GEN_POS: begin
          if (int'(pos_draw) < N) begin
`ifdef BCH_TRAFFIC_BURST_EN
            if (burst_q) begin
              for (int i = 0; i < MAX_ERR; i++) begin
                int idx;
                idx = int'(pos_draw) + i;
                if (idx >= N) idx = idx - N;
                if (i < int'(nerr_q)) err_q[idx] <= 1'b1;
              end
              rem_q   <= '0;
              state_q <= ISSUE;
              vdin_q  <= 1'b1;
            end else
`endif
            if (!err_q[pos_draw]) begin
              err_q[pos_draw] <= 1'b1;
              rem_q           <= rem_q - NERR_W'(1);
              if (rem_q == NERR_W'(1)) begin
                state_q <= ISSUE;
                vdin_q  <= 1'b1;
              end
            end
          end
        end
        ISSUE: begin
          if (bus.rdin) begin
            vdin_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Expected-data storage; contents need no reset, pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {din_q, (int'(nerr_q) <= T)};
  end

  // FIFO pointers and scoreboard statistics
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wrong_now_q <= 1'b0;
      wrong_q     <= 1'b0;
      underflow_q <= 1'b0;
      frames_q    <= '0;
      unc_q       <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
        frames_q <= frames_q + 32'd1;
        if (!head_corr) unc_q <= unc_q + 32'd1;
      end
      if (bus.vdout && empty) underflow_q <= 1'b1;
      wrong_now_q <= mism;
      wrong_q     <= wrong_q | mism;
    end
  end

  assign bus.vdin        = vdin_q;
  assign bus.din         = din_q;
  assign bus.error       = err_q;
  assign bus.nerr        = nerr_q;
  assign wrong_now_o     = wrong_now_q;
  assign wrong_o         = wrong_q;
  assign underflow_o     = underflow_q;
  assign frames_o        = frames_q;
  assign uncorrectable_o = unc_q;
  assign busy_o          = !empty || (state_q != IDLE);

endmodule

// File: tb/tb_bch_traffic_checker.sv
// Directed bench for bch_traffic_checker (N=31, K=11, T=5, MAX_ERR=7, DEPTH=4,
// SEED=1) with a behavioural encoder/decoder loop around it.
module tb_bch_traffic_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        wrong_now, wrong, underflow, busy;
  logic [31:0] frames, uncorr;

  bch_traffic_checker_if #(.N(31), .K(11), .NERR_W(3)) bus ();

  bch_traffic_checker #(
    .N(31), .K(11), .T(5), .MAX_ERR(7), .DEPTH(4), .SEED(32'd1)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .enable_i        (enable),
`ifdef BCH_TRAFFIC_BURST_EN
    .burst_i         (1'b0),
`endif
    .bus             (bus),
    .wrong_now_o     (wrong_now),
    .wrong_o         (wrong),
    .underflow_o     (underflow),
    .frames_o        (frames),
    .uncorrectable_o (uncorr),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] din;
    logic [30:0] err;
    int          nerr;
  } frame_t;

  frame_t      q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0, xfers = 0, pops = 0, exp_unc = 0;
  int          wn_cnt = 0, wn_cyc = -1, flip_cyc = -100;
  int          dec_budget = 0;
  bit          dec_rand = 0, rd_rand = 0, rd_en = 0, flip_arm = 0;
  bit          hold_pend = 0;
  logic [10:0] hold_din;
  logic [30:0] hold_err;
  int          vd_cnt, lat, guard;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of encoder-ready and decoder-model activity, driven at negedge
  task automatic step();
    frame_t fr;
    @(negedge clk);
    cyc++;
    if (wrong_now) begin
      wn_cnt++;
      wn_cyc = cyc;
    end
    if (hold_pend) begin
      chk("hold_vdin", bus.vdin, 1);
      chk("hold_din", bus.din, hold_din);
      chk("hold_err", bus.error, hold_err);
    end
    bus.vdout = 1'b0;
    bus.dout  = '0;
    if (dec_budget > 0 && q.size() > 0 && (!dec_rand || $urandom_range(0, 2) != 0)) begin
      fr = q.pop_front();
      bus.dout = (fr.nerr <= 5) ? fr.din : ~fr.din;
      if (flip_arm && fr.nerr <= 5) begin
        bus.dout[0] = ~bus.dout[0];
        flip_arm = 0;
        flip_cyc = cyc;
      end
      bus.vdout = 1'b1;
      dec_budget--;
      pops++;
      if (fr.nerr > 5) exp_unc++;
    end
    bus.rdin = rd_rand ? ($urandom_range(0, 1) == 1) : rd_en;
    if (bus.vdin && bus.rdin) begin
      fr.din  = bus.din;
      fr.err  = bus.error;
      fr.nerr = int'(bus.nerr);
      q.push_back(fr);
      xfers++;
      chk("xfer_popcount", $countones(bus.error), bus.nerr);
      chk("xfer_nerr_max", bus.nerr <= 3'd7, 1);
    end
    hold_pend = bus.vdin && !bus.rdin;
    hold_din  = bus.din;
    hold_err  = bus.error;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0;
    bus.rdin = 1'b0; bus.vdout = 1'b0; bus.dout = '0;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_vdin", bus.vdin, 0);
    chk("rst_din", bus.din, 0);
    chk("rst_error", bus.error, 0);
    chk("rst_nerr", bus.nerr, 0);
    chk("rst_wrong_now", wrong_now, 0);
    chk("rst_wrong", wrong, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_frames", frames, 0);
    chk("rst_uncorr", uncorr, 0);
    chk("rst_busy", busy, 0);

    // disabled: nothing issued
    reset = 1'b0;
    vd_cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.vdin) vd_cnt++;
    end
    chk("idle_vdin_cnt", vd_cnt, 0);
    chk("idle_busy", busy, 0);

    // vdout with nothing queued
    bus.vdout = 1'b1;
    @(negedge clk);
    bus.vdout = 1'b0;
    chk("uf_wrong_now", wrong_now, 1);
    @(negedge clk);
    chk("uf_wrong_now_end", wrong_now, 0);
    chk("uf_underflow", underflow, 1);
    chk("uf_wrong", wrong, 1);
    chk("uf_frames", frames, 0);
    chk("uf_busy", busy, 0);

    // reset in the middle of GEN_POS of the first frame
    reset = 1'b1;
    @(negedge clk);
    chk("rst2_underflow", underflow, 0);
    chk("rst2_wrong", wrong, 0);
    reset = 1'b0;
    enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_vdin", bus.vdin, 0);
    chk("mid_busy", busy, 1);
    reset = 1'b1;
    #1;
    chk("mid_rst_vdin", bus.vdin, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    chk("mid_rst_hold_vdin", bus.vdin, 0);
    reset = 1'b0;

    // first frame from SEED=1: din=1, nerr=3, positions 2,1,3
    lat = 0;
    while (!bus.vdin && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("first_latency", lat, 6);
    chk("first_din", bus.din, 11'h001);
    chk("first_nerr", bus.nerr, 3);
    chk("first_error", bus.error, 31'h0000_000E);
    repeat (5) @(negedge clk);
    chk("first_hold_vdin", bus.vdin, 1);
    chk("first_hold_din", bus.din, 11'h001);
    chk("first_hold_error", bus.error, 31'h0000_000E);

    // FIFO full with no decoder output
    rd_en = 1; dec_budget = 0;
    repeat (150) step();
    chk("full_xfers", xfers, 4);
    chk("full_vdin", bus.vdin, 0);
    chk("full_busy", busy, 1);
    dec_budget = 1;
    repeat (150) step();
    chk("one_pop_xfers", xfers, 5);
    chk("one_pop_frames", frames, 1);
    chk("one_pop_wrong", wrong, 0);

    // 200 frames with random backpressure and decoder gaps
    dec_budget = 1000000; dec_rand = 1; rd_rand = 1;
    guard = 0;
    while (pops < 201 && guard < 30000) begin
      step();
      guard++;
    end
    chk("main_pops", pops, 201);
    dec_budget = 0;
    step();
    chk("main_frames", frames, pops);
    chk("main_uncorr", uncorr, exp_unc);
    chk("main_wrong", wrong, 0);
    chk("main_underflow", underflow, 0);
    chk("main_wn_cnt", wn_cnt, 0);

    // single corrupted correctable frame
    dec_budget = 1000000; dec_rand = 0; rd_rand = 0; rd_en = 1; flip_arm = 1;
    guard = 0;
    while (flip_arm && guard < 500) begin
      step();
      guard++;
    end
    chk("flip_found", flip_arm, 0);
    repeat (3) step();
    chk("flip_wn_cnt", wn_cnt, 1);
    chk("flip_wn_cycle", wn_cyc, flip_cyc + 1);
    chk("flip_wrong", wrong, 1);
    repeat (20) step();
    chk("flip_wn_once", wn_cnt, 1);
    chk("flip_wrong_sticky", wrong, 1);
    chk("flip_underflow", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
